// File: rtl/ball_launch_move_if.sv
// Ball controller bus: game/drawing side (master) to ball controller (slave).
//   startOfFrame  one-cycle pulse per video frame
//   launchReq     one-cycle launch pulse
//   topLeftBatX/Y bat top-left position
//   batHit        ball/bat collision pulse
//   brickHitX/Y   brick side / brick top-bottom collision pulses
//   topLeftX/Y    registered ball top-left position
//   preStart      high while the ball rides on the bat
//   ballLost      one-cycle pulse when the ball falls out the bottom
interface ball_launch_move_if;
    logic        startOfFrame;
    logic        launchReq;
    logic [10:0] topLeftBatX;
    logic [10:0] topLeftBatY;
    logic        batHit;
    logic        brickHitX;
    logic        brickHitY;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic        preStart;
    logic        ballLost;

    modport master (
        output startOfFrame, launchReq, topLeftBatX, topLeftBatY, batHit, brickHitX, brickHitY,
        input  topLeftX, topLeftY, preStart, ballLost
    );

    modport slave (
        input  startOfFrame, launchReq, topLeftBatX, topLeftBatY, batHit, brickHitX, brickHitY,
        output topLeftX, topLeftY, preStart, ballLost
    );
endinterface

// File: rtl/ball_launch_move.sv
// Ball position controller. Keeps the ball on the bat until launched, then moves it once per
// frame, bouncing off walls, bat and bricks; reports a lost ball when it exits the bottom.
//   clk    system clock
//   reset  synchronous, active-high
//   bus    ball_launch_move_if.slave (frame/launch/hit inputs, position/status outputs)
module ball_launch_move #(
    parameter int BAT_OFFSET_X = 20,
    parameter int BAT_OFFSET_Y = 14,
    parameter int INIT_VX      = 2,
    parameter int INIT_VY      = 3,
    parameter int LEFT_LIMIT   = 0,
    parameter int RIGHT_LIMIT  = 623,
    parameter int TOP_LIMIT    = 0,
    parameter int BOTTOM_LIMIT = 463
) (
    input  logic               clk,
    input  logic               reset,
    ball_launch_move_if.slave  bus
);

    localparam logic signed [11:0] LeftLim   = 12'(LEFT_LIMIT);
    localparam logic signed [11:0] RightLim  = 12'(RIGHT_LIMIT);
    localparam logic signed [11:0] TopLim    = 12'(TOP_LIMIT);
    localparam logic signed [11:0] BottomLim = 12'(BOTTOM_LIMIT);

    typedef enum logic [1:0] {StPreStart, StMoving, StLost} state_e;

    state_e             state_q, state_d;
    logic [10:0]        x_q, x_d, y_q, y_d;
    logic signed [4:0]  vx_q, vx_d, vy_q, vy_d;
    logic               bat_f_q, bat_f_d, bx_f_q, bx_f_d, by_f_q, by_f_d;

    logic [10:0]        bat_x, bat_y;
    logic signed [4:0]  vx_flip, vy_flip;
    logic signed [11:0] nx, ny;

    assign bat_x = bus.topLeftBatX + 11'(BAT_OFFSET_X);
    assign bat_y = bus.topLeftBatY - 11'(BAT_OFFSET_Y);

    // Collision reflections ahead of the move; a bat hit only matters while descending.
    assign vy_flip = (by_f_q || (bat_f_q && vy_q > 5'sd0)) ? -vy_q : vy_q;
    assign vx_flip = bx_f_q ? -vx_q : vx_q;

    assign nx = $signed({1'b0, x_q}) + {{7{vx_flip[4]}}, vx_flip};
    assign ny = $signed({1'b0, y_q}) + {{7{vy_flip[4]}}, vy_flip};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StPreStart;
            x_q     <= '0;
            y_q     <= '0;
            vx_q    <= '0;
            vy_q    <= '0;
            bat_f_q <= 1'b0;
            bx_f_q  <= 1'b0;
            by_f_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            bat_f_q <= bat_f_d;
            bx_f_q  <= bx_f_d;
            by_f_q  <= by_f_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        bat_f_d = 1'b0;
        bx_f_d  = 1'b0;
        by_f_d  = 1'b0;

        unique case (state_q)
            StPreStart: begin
                x_d = bat_x;
                y_d = bat_y;
                if (bus.launchReq) begin
                    state_d = StMoving;
                    vx_d    = 5'(INIT_VX);
                    vy_d    = 5'(-INIT_VY);
                end
            end
            StMoving: begin
                if (bus.startOfFrame) begin
                    // Flags are consumed this frame; a hit in this same cycle waits for the next.
                    bat_f_d = bus.batHit;
                    bx_f_d  = bus.brickHitX;
                    by_f_d  = bus.brickHitY;
                    vx_d    = vx_flip;
                    vy_d    = vy_flip;
                    if (nx < LeftLim) begin
                        x_d  = LeftLim[10:0];
                        vx_d = -vx_flip;
                    end else if (nx > RightLim) begin
                        x_d  = RightLim[10:0];
                        vx_d = -vx_flip;
                    end else begin
                        x_d = nx[10:0];
                    end
                    if (ny < TopLim) begin
                        y_d  = TopLim[10:0];
                        vy_d = -vy_flip;
                    end else if (ny > BottomLim) begin
                        // Freeze the last on-screen position for the lost cycle.
                        state_d = StLost;
                        x_d     = x_q;
                    end else begin
                        y_d = ny[10:0];
                    end
                end else begin
                    bat_f_d = bat_f_q | bus.batHit;
                    bx_f_d  = bx_f_q | bus.brickHitX;
                    by_f_d  = by_f_q | bus.brickHitY;
                end
            end
            StLost: begin
                // Reattach to the bat so it is already there when preStart rises.
                x_d     = bat_x;
                y_d     = bat_y;
                state_d = StPreStart;
            end
            default: state_d = StPreStart;
        endcase
    end

    assign bus.topLeftX = x_q;
    assign bus.topLeftY = y_q;
    assign bus.preStart = (state_q == StPreStart);
    assign bus.ballLost = (state_q == StLost) && !reset;

endmodule

// File: tb/tb_ball_launch_move.sv
module tb_ball_launch_move;

    logic clk;
    logic reset;

    ball_launch_move_if bus ();

    ball_launch_move dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    x;
        int    y;
        int    ps;
        int    bl;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq({e.tag, ".x"},  32'(bus.topLeftX), e.x);
            check_eq({e.tag, ".y"},  32'(bus.topLeftY), e.y);
            check_eq({e.tag, ".ps"}, 32'(bus.preStart), e.ps);
            check_eq({e.tag, ".bl"}, 32'(bus.ballLost), e.bl);
        end
    endtask

    // Drive one cycle of pulses, record what must be visible after the edge, then compare.
    task automatic cyc(input string tag, input logic sof, input logic lr, input logic bh,
                       input logic bx, input logic by, input int x, input int y,
                       input int ps, input int bl);
        exp_t e;
        bus.startOfFrame = sof;
        bus.launchReq    = lr;
        bus.batHit       = bh;
        bus.brickHitX    = bx;
        bus.brickHitY    = by;
        e.tag = tag; e.x = x; e.y = y; e.ps = ps; e.bl = bl;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.startOfFrame = 1'b0;
        bus.launchReq    = 1'b0;
        bus.batHit       = 1'b0;
        bus.brickHitX    = 1'b0;
        bus.brickHitY    = 1'b0;
        drain();
    endtask

    task automatic bat(input int bx, input int by);
        bus.topLeftBatX = 11'(bx);
        bus.topLeftBatY = 11'(by);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc("rst", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.startOfFrame = 1'b0;
        bus.launchReq    = 1'b0;
        bus.batHit       = 1'b0;
        bus.brickHitX    = 1'b0;
        bus.brickHitY    = 1'b0;
        bat(300, 440);

        // Reset and hold on the bat
        do_reset();
        cyc("hold0", 0, 0, 0, 0, 0, 320, 426, 1, 0);
        cyc("hold1", 0, 0, 0, 0, 0, 320, 426, 1, 0);
        cyc("hold_hit", 0, 0, 1, 1, 1, 320, 426, 1, 0);
        cyc("hold_sof", 1, 0, 0, 0, 0, 320, 426, 1, 0);
        bat(310, 440);
        cyc("bat_move", 0, 0, 0, 0, 0, 330, 426, 1, 0);

        // Launch and three frames
        bat(300, 440);
        cyc("pre", 0, 0, 0, 0, 0, 320, 426, 1, 0);
        cyc("launch", 0, 1, 0, 0, 0, 320, 426, 0, 0);
        cyc("idle", 0, 0, 0, 0, 0, 320, 426, 0, 0);
        cyc("f1", 1, 0, 0, 0, 0, 322, 423, 0, 0);
        cyc("stable", 0, 0, 0, 0, 0, 322, 423, 0, 0);
        cyc("f2", 1, 0, 0, 0, 0, 324, 420, 0, 0);
        cyc("f3", 1, 0, 0, 0, 0, 326, 417, 0, 0);

        // Reset mid-flight
        do_reset();

        // Right wall
        bat(600, 440);
        cyc("rw_pre", 0, 0, 0, 0, 0, 620, 426, 1, 0);
        cyc("rw_launch", 0, 1, 0, 0, 0, 620, 426, 0, 0);
        cyc("rw_f1", 1, 0, 0, 0, 0, 622, 423, 0, 0);
        cyc("rw_clamp", 1, 0, 0, 0, 0, 623, 420, 0, 0);
        cyc("rw_back", 1, 0, 0, 0, 0, 621, 417, 0, 0);
        do_reset();

        // Top wall, bat bounce, brick hits
        bat(100, 14);
        cyc("bb_pre", 0, 0, 0, 0, 0, 120, 0, 1, 0);
        cyc("bb_launch", 0, 1, 0, 0, 0, 120, 0, 0, 0);
        cyc("bb_top", 1, 0, 0, 0, 0, 122, 0, 0, 0);
        cyc("bb_down1", 1, 0, 0, 0, 0, 124, 3, 0, 0);
        cyc("bb_down2", 1, 0, 0, 0, 0, 126, 6, 0, 0);
        cyc("bb_hit", 0, 0, 1, 0, 0, 126, 6, 0, 0);
        cyc("bb_bounce", 1, 0, 0, 0, 0, 128, 3, 0, 0);
        cyc("bb_hit2", 0, 0, 1, 0, 0, 128, 3, 0, 0);
        cyc("bb_noflip", 1, 0, 0, 0, 0, 130, 0, 0, 0);
        cyc("bb_top2", 1, 0, 0, 0, 0, 132, 0, 0, 0);
        cyc("sim_down", 1, 0, 0, 0, 0, 134, 3, 0, 0);
        cyc("sim_hits", 0, 0, 1, 0, 1, 134, 3, 0, 0);
        cyc("sim_single", 1, 0, 0, 0, 0, 136, 0, 0, 0);
        cyc("bx_hit", 0, 0, 0, 1, 0, 136, 0, 0, 0);
        cyc("bx_flip", 1, 0, 0, 0, 0, 134, 0, 0, 0);
        cyc("bx_late", 1, 0, 0, 1, 0, 132, 3, 0, 0);
        cyc("bx_applied", 1, 0, 0, 0, 0, 134, 6, 0, 0);
        do_reset();

        // Launch coincident with start of frame
        bat(200, 440);
        cyc("co_pre", 0, 0, 0, 0, 0, 220, 426, 1, 0);
        cyc("co_launch", 1, 1, 0, 0, 0, 220, 426, 0, 0);
        cyc("co_idle", 0, 0, 0, 0, 0, 220, 426, 0, 0);
        cyc("co_f1", 1, 0, 0, 0, 0, 222, 423, 0, 0);
        do_reset();

        // Bottom exit
        bat(50, 479);
        cyc("lo_pre", 0, 0, 0, 0, 0, 70, 465, 1, 0);
        cyc("lo_launch", 0, 1, 0, 0, 0, 70, 465, 0, 0);
        cyc("lo_f1", 1, 0, 0, 0, 0, 72, 462, 0, 0);
        cyc("lo_flip", 0, 0, 0, 0, 1, 72, 462, 0, 0);
        cyc("lo_lost", 1, 0, 0, 0, 0, 72, 462, 0, 1);
        cyc("lo_back", 0, 0, 0, 0, 0, 70, 465, 1, 0);
        cyc("lo_hold", 0, 0, 0, 0, 0, 70, 465, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
